// File: rtl/iomem_sample_fifo_pkg.sv
// Shared constants for the iomem sample FIFO responder.
// Register offsets, STATUS/CTRL bit positions and the decode helper.
package iomem_sample_fifo_pkg;

    localparam int LVL_W = 9;

    localparam logic [7:0] REG_DATA   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_CTRL   = 8'h08;

    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;
    localparam int ST_UND   = 19;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_THR_LSB = 8;
    localparam int CTRL_IRQEN   = 16;

    typedef enum logic [1:0] {
        SEL_DATA,
        SEL_STATUS,
        SEL_CTRL,
        SEL_NONE
    } reg_sel_e;

    // Word index (addr[7:2]) to register select.
    function automatic reg_sel_e decode_reg(input logic [5:0] word);
        reg_sel_e v;
        v = SEL_NONE;
        if (word == REG_DATA[7:2])
            v = SEL_DATA;
        else if (word == REG_STATUS[7:2])
            v = SEL_STATUS;
        else if (word == REG_CTRL[7:2])
            v = SEL_CTRL;
        return v;
    endfunction

endpackage

// File: rtl/iomem_sample_fifo_sync.sv
// Synchronous FIFO with registered read; a pop of an empty FIFO yields zero.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo_sync
    import iomem_sample_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic [LVL_W-1:0] o_level,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop,
    output logic             o_underrun
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_dout;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full     = (r_level == LVL_W'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign w_pop_ok   = i_pop && !o_empty;
    assign w_push_ok  = i_push && (!o_full || i_pop);
    assign o_drop     = i_push && o_full && !i_pop;
    assign o_underrun = i_pop && o_empty;
    assign o_level    = r_level;
    assign o_dout     = r_dout;

    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_dout  <= '0;
        end else begin
            if (i_pop)
                r_dout <= o_empty ? '0 : r_mem[r_rptr];
            if (i_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_push_ok)
                    r_wptr <= r_wptr + AW'(1);
                if (w_pop_ok)
                    r_rptr <= r_rptr + AW'(1);
                unique case ({w_push_ok, w_pop_ok})
                    2'b10:   r_level <= r_level + LVL_W'(1);
                    2'b01:   r_level <= r_level - LVL_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/iomem_sample_fifo.sv
// iomem bus responder feeding a stereo sample FIFO popped at audio rate.
// Holds bus decode, ready pulse, CTRL/STATUS registers and low-watermark irq.
module iomem_sample_fifo
    import iomem_sample_fifo_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          DEPTH     = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic        sample_req,
    output logic [31:0] sample_out,
    output logic        irq
);

    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_enable;
    logic [7:0]  r_thr;
    logic        r_irq_en;
    logic        r_ovf;
    logic        r_und;
    logic        r_irq;

    logic             w_sel;
    logic             w_commit;
    logic             w_wr;
    reg_sel_e         w_reg;
    logic             w_push;
    logic             w_pop;
    logic             w_ctrl_wr;
    logic             w_flush;
    logic             w_clr_ovf;
    logic             w_clr_und;
    logic [LVL_W-1:0] w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic             w_udf;
    logic [31:0]      w_status;
    logic [31:0]      w_ctrl;
    logic [31:0]      w_rd_val;
    logic             w_unused;

    assign w_unused = &{1'b0, iomem_addr[1:0]};

    // Only one edge per access commits: the one that raises ready.
    assign w_sel    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign w_commit = w_sel && !r_ready;
    assign w_wr     = |iomem_wstrb;
    assign w_reg    = decode_reg(iomem_addr[7:2]);

    assign w_push    = w_commit && w_wr && (w_reg == SEL_DATA);
    assign w_pop     = sample_req && r_enable;
    assign w_ctrl_wr = w_commit && (w_reg == SEL_CTRL);
    assign w_flush   = w_ctrl_wr && iomem_wstrb[0] && r_enable
                     && !iomem_wdata[CTRL_EN];
    assign w_clr_ovf = w_commit && (w_reg == SEL_STATUS)
                     && iomem_wstrb[2] && iomem_wdata[ST_OVF];
    assign w_clr_und = w_commit && (w_reg == SEL_STATUS)
                     && iomem_wstrb[2] && iomem_wdata[ST_UND];

    sample_fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst_n    (resetn),
        .i_flush    (w_flush),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_din      (iomem_wdata),
        .o_dout     (sample_out),
        .o_level    (w_level),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_drop     (w_drop),
        .o_underrun (w_udf)
    );

    always_comb begin
        w_status                = '0;
        w_status[LVL_W-1:0]     = w_level;
        w_status[ST_EMPTY]      = w_empty;
        w_status[ST_FULL]       = w_full;
        w_status[ST_OVF]        = r_ovf;
        w_status[ST_UND]        = r_und;
        w_ctrl                  = '0;
        w_ctrl[CTRL_EN]         = r_enable;
        w_ctrl[CTRL_THR_LSB +: 8] = r_thr;
        w_ctrl[CTRL_IRQEN]      = r_irq_en;
    end

    always_comb begin
        w_rd_val = '0;
        unique case (w_reg)
            SEL_STATUS: w_rd_val = w_status;
            SEL_CTRL:   w_rd_val = w_ctrl;
            default:    w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_enable <= 1'b0;
            r_thr    <= '0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_und    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ready <= w_commit;
            r_rdata <= w_commit ? w_rd_val : '0;
            if (w_ctrl_wr) begin
                if (iomem_wstrb[0])
                    r_enable <= iomem_wdata[CTRL_EN];
                if (iomem_wstrb[1])
                    r_thr <= iomem_wdata[CTRL_THR_LSB +: 8];
                if (iomem_wstrb[2])
                    r_irq_en <= iomem_wdata[CTRL_IRQEN];
            end
            // A new event wins over a same-cycle clear.
            r_ovf <= w_drop | (r_ovf & ~w_clr_ovf);
            r_und <= w_udf | (r_und & ~w_clr_und);
            r_irq <= r_irq_en && r_enable && (w_level <= {1'b0, r_thr});
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign irq         = r_irq;

endmodule

// File: tb/tb_iomem_sample_fifo.sv
// Scoreboard bench for iomem_sample_fifo: bus reads and sample pops
// push expected values to a queue and compare when the DUT responds.
module tb_iomem_sample_fifo;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam int          DEP  = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        sample_req;
    logic [31:0] sample_out;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_q[$];
    logic [31:0] exp_q[$];
    bit          m_en, m_ie, m_ovf, m_und;
    logic [7:0]  m_thr;
    logic [31:0] m_smp;

    iomem_sample_fifo #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEP)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .sample_req  (sample_req),
        .sample_out  (sample_out),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status();
        int n;
        n = m_q.size();
        return {12'h0, m_und, m_ovf, n == DEP, n == 0, 7'h0, 9'(n)};
    endfunction

    function automatic logic [31:0] exp_read(input logic [7:0] off);
        if (off == 8'h04) return exp_status();
        if (off == 8'h08) return {15'h0, m_ie, m_thr, 7'h0, m_en};
        return 32'h0;
    endfunction

    function automatic void model_write(input logic [7:0] off,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
        if (off == 8'h00 && s != 4'h0) begin
            if (m_q.size() < DEP) m_q.push_back(d);
            else m_ovf = 1'b1;
        end else if (off == 8'h04 && s[2]) begin
            if (d[18]) m_ovf = 1'b0;
            if (d[19]) m_und = 1'b0;
        end else if (off == 8'h08) begin
            if (s[0]) begin
                if (m_en && !d[0]) m_q.delete();
                m_en = d[0];
            end
            if (s[1]) m_thr = d[15:8];
            if (s[2]) m_ie = d[16];
        end
    endfunction

    function automatic logic [31:0] model_pop();
        if (m_en) begin
            if (m_q.size() > 0) m_smp = m_q.pop_front();
            else begin
                m_smp = 32'h0;
                m_und = 1'b1;
            end
        end
        return m_smp;
    endfunction

    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit with_pop,
                            output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = 32'h0;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wdata = d;
        iomem_wstrb = s;
        sample_req  = with_pop;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            sample_req = 1'b0;
            if (iomem_ready) begin
                got = 1'b1;
                rd  = iomem_rdata;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL bus_timeout addr=%h got=no_ready exp=ready", a);
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d,
                      input logic [3:0] s);
        logic [31:0] rd;
        model_write(off, d, s);
        bus_xfer(BASE + {24'h0, off}, d, s, 1'b0, rd);
    endtask

    task automatic rd_check(input logic [7:0] off, input string name);
        logic [31:0] rd, e;
        exp_q.push_back(exp_read(off));
        bus_xfer(BASE + {24'h0, off}, 32'h0, 4'h0, 1'b0, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, rd, e);
        end
    endtask

    task automatic do_pop(input string name);
        logic [31:0] e;
        exp_q.push_back(model_pop());
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (sample_out !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, sample_out, e);
        end
    endtask

    task automatic push_pop(input logic [31:0] d, input string name);
        logic [31:0] rd, e;
        exp_q.push_back(model_pop());
        model_write(8'h00, d, 4'hF);
        bus_xfer(BASE, d, 4'hF, 1'b1, rd);
        e = exp_q.pop_front();
        checks++;
        if (sample_out !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, sample_out, e);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus got=%b/%h exp=0/0", iomem_ready, iomem_rdata);
        end
        checks++;
        if (sample_out !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got=%h/%b exp=0/0", sample_out, irq);
        end
        exp_q.push_back(32'h0001_0000);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'h4;
        iomem_wstrb = 4'h0;
        @(negedge clk);
        checks++;
        if (iomem_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_n1 got=%b exp=1", iomem_ready);
        end
        checks++;
        if (iomem_rdata !== exp_q[0]) begin
            failures++;
            $display("FAIL reset_status got=%h exp=%h", iomem_rdata, exp_q[0]);
        end
        void'(exp_q.pop_front());
        @(negedge clk);
        checks++;
        if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL ready_n2 got=%b/%h exp=0/0", iomem_ready, iomem_rdata);
        end
        iomem_valid = 1'b0;
        rd_check(8'h08, "reset_ctrl");
    endtask

    task automatic test_fifo_order();
        wr(8'h08, 32'h1, 4'h1);
        rd_check(8'h08, "ctrl_enable");
        wr(8'h00, 32'h1111_2222, 4'hF);
        wr(8'h00, 32'h3333_4444, 4'h1);
        rd_check(8'h00, "data_read_zero");
        rd_check(8'h04, "status_lvl2");
        do_pop("pop_first");
        rd_check(8'h04, "status_lvl1");
        do_pop("pop_second");
        rd_check(8'h04, "status_lvl0");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++)
            wr(8'h00, 32'hA000_0000 + i, 4'hF);
        rd_check(8'h04, "status_full_ovf");
        checks++;
        if (exp_status() !== 32'h0006_0010) begin
            failures++;
            $display("FAIL model_full got=%h exp=00060010", exp_status());
        end
        wr(8'h04, 32'h0004_0000, 4'h4);
        rd_check(8'h04, "status_ovf_w1c");
        push_pop(32'hBBBB_0000, "push_pop_full");
        rd_check(8'h04, "status_full_no_ovf");
        for (int i = 0; i < DEP; i++)
            do_pop($sformatf("drain_%0d", i));
        rd_check(8'h04, "status_drained");
    endtask

    task automatic test_underrun();
        wr(8'h00, 32'hC0DE_0001, 4'hF);
        do_pop("pop_c1");
        wr(8'h00, 32'hC0DE_0002, 4'hF);
        wr(8'h08, 32'h0, 4'h1);
        do_pop("pop_disabled_hold");
        rd_check(8'h04, "status_flushed");
        wr(8'h08, 32'h1, 4'h1);
        do_pop("pop_empty_zero");
        rd_check(8'h04, "status_underrun");
        wr(8'h04, 32'h0008_0000, 4'h4);
        push_pop(32'hD00D_0001, "push_pop_empty");
        rd_check(8'h04, "status_und_lvl1");
        wr(8'h04, 32'h0008_0000, 4'h4);
    endtask

    task automatic test_irq();
        wr(8'h08, 32'h0, 4'h7);
        wr(8'h08, 32'h0001_0401, 4'h7);
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_lvl0 got=%b exp=1", irq);
        end
        for (int i = 0; i < 6; i++)
            wr(8'h00, 32'hE000_0000 + i, 4'hF);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_lvl6 got=%b exp=0", irq);
        end
        do_pop("irq_pop1");
        do_pop("irq_pop2");
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_latency got=%b exp=0", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_rise got=%b exp=1", irq);
        end
        wr(8'h00, 32'hE000_0010, 4'hF);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_hold got=%b exp=1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_fall got=%b exp=0", irq);
        end
    endtask

    task automatic test_decode();
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wdata = 32'hFFFF_FFFF;
        iomem_wstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0) begin
                failures++;
                $display("FAIL foreign_addr_%0d got=%b/%h exp=0/0",
                         i, iomem_ready, iomem_rdata);
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        rd_check(8'h04, "status_after_foreign");
        wr(8'h10, 32'hFFFF_FFFF, 4'hF);
        rd_check(8'h10, "unmapped_read");
        rd_check(8'h04, "status_after_unmapped");
    endtask

    initial begin
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        sample_req  = 1'b0;
        m_en  = 1'b0;
        m_ie  = 1'b0;
        m_ovf = 1'b0;
        m_und = 1'b0;
        m_thr = 8'h0;
        m_smp = 32'h0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        test_reset();
        test_fifo_order();
        test_overflow();
        test_underrun();
        test_irq();
        test_decode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
